// File: rtl/bram_burst_if.sv
// Burst command, read/write stream and RAM port bundle for bram_burst_ctrl.
// The slave modport is the controller's view; master is the surrounding system.
interface bram_burst_if #(
  parameter int unsigned MEMORY_DEPTH = 4096,
  parameter int unsigned DATA_WIDTH   = 16
);
  localparam int unsigned ADDRESS_WIDTH = $clog2(MEMORY_DEPTH);

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_write;
  logic [ADDRESS_WIDTH-1:0] cmd_address;
  logic [ADDRESS_WIDTH-1:0] cmd_length;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     rd_valid;
  logic                     rd_ready;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     wr_valid;
  logic                     wr_ready;
  logic                     done;
  logic                     mem_wr;
  logic [DATA_WIDTH-1:0]    mem_data;
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0]    mem_q;

  modport master (
    output cmd_valid, cmd_write, cmd_address, cmd_length, rd_ready, wr_data, wr_valid, mem_q,
    input  cmd_ready, rd_data, rd_valid, wr_ready, done, mem_wr, mem_data, mem_address
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_address, cmd_length, rd_ready, wr_data, wr_valid, mem_q,
    output cmd_ready, rd_data, rd_valid, wr_ready, done, mem_wr, mem_data, mem_address
  );
endinterface

// File: rtl/bram_burst_ctrl.sv
// Burst controller in front of a registered-address block RAM: turns base+length commands into
// word-by-word RAM accesses, streaming reads out through a 2-entry FIFO and writes straight in.
module bram_burst_ctrl #(
  parameter int unsigned MEMORY_DEPTH = 4096,
  parameter int unsigned DATA_WIDTH   = 16
) (
  input logic       clk,
  input logic       rst,
  bram_burst_if.slave bus
);
  localparam int unsigned ADDRESS_WIDTH = $clog2(MEMORY_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] LastAddr = ADDRESS_WIDTH'(MEMORY_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e                   state_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [ADDRESS_WIDTH-1:0] issue_left_q;
  logic [ADDRESS_WIDTH-1:0] beat_left_q;
  logic [DATA_WIDTH-1:0]    fifo_q [2];
  logic [1:0]               count_q;
  // addr_pend_q: addr_q is a freshly issued word whose data shows on mem_q next cycle.
  // data_pend_q: mem_q holds an issued word not yet captured into the FIFO.
  logic                     addr_pend_q;
  logic                     data_pend_q;
  logic                     done_q;

  logic                     accept;
  logic                     wr_beat;
  logic                     pop;
  logic                     push;
  logic                     issue;
  logic                     data_pend_next;
  logic [1:0]               count_after_pop;
  logic [1:0]               count_next;
  logic [ADDRESS_WIDTH-1:0] addr_inc;

  always_comb begin
    accept          = bus.cmd_valid && (state_q == StIdle);
    wr_beat         = (state_q == StWrite) && bus.wr_valid;
    pop             = (state_q == StRead) && (count_q != 2'd0) && bus.rd_ready;
    count_after_pop = count_q - {1'b0, pop};
    push            = data_pend_q && (count_after_pop != 2'd2);
    count_next      = count_after_pop + {1'b0, push};
    // An uncaptured word stays readable as long as the RAM address is held still.
    data_pend_next  = addr_pend_q || (data_pend_q && !push);
    // Only move the address on when the word now on its way is sure to fit next cycle.
    issue           = (state_q == StRead) && (issue_left_q != '0) &&
                      (!data_pend_next || (count_next != 2'd2));
    addr_inc        = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      issue_left_q <= '0;
      beat_left_q  <= '0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      count_q      <= 2'd0;
      addr_pend_q  <= 1'b0;
      data_pend_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (bus.cmd_length == '0) begin
              done_q <= 1'b1;
            end else if (bus.cmd_write) begin
              state_q     <= StWrite;
              addr_q      <= bus.cmd_address;
              beat_left_q <= bus.cmd_length;
            end else begin
              state_q      <= StRead;
              addr_q       <= bus.cmd_address;
              issue_left_q <= bus.cmd_length - 1'b1;
              beat_left_q  <= bus.cmd_length;
              addr_pend_q  <= 1'b1;
            end
          end
        end
        StWrite: begin
          if (wr_beat) begin
            addr_q      <= addr_inc;
            beat_left_q <= beat_left_q - 1'b1;
            if (beat_left_q == ADDRESS_WIDTH'(1)) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
        end
        StRead: begin
          addr_pend_q <= issue;
          data_pend_q <= data_pend_next;
          count_q     <= count_next;
          if (issue) begin
            addr_q       <= addr_inc;
            issue_left_q <= issue_left_q - 1'b1;
          end
          if (pop) begin
            fifo_q[0]   <= fifo_q[1];
            beat_left_q <= beat_left_q - 1'b1;
            if (beat_left_q == ADDRESS_WIDTH'(1)) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
          if (push) begin
            fifo_q[count_after_pop[0]] <= bus.mem_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cmd_ready   = (state_q == StIdle);
  assign bus.rd_data     = fifo_q[0];
  assign bus.rd_valid    = (count_q != 2'd0);
  assign bus.wr_ready    = (state_q == StWrite);
  assign bus.done        = done_q;
  assign bus.mem_wr      = wr_beat && !rst;
  assign bus.mem_data    = (state_q == StWrite) ? bus.wr_data : '0;
  assign bus.mem_address = addr_q;
endmodule
